mem_bus_arbiter: RTL and testbench

- Shares the single memory/peripheral bus between two requesters: m0 (CPU) and m1 (DMA/UART engine).
- Bus signals: device select, 16-bit address, we, oe, write data, read data.
- Arbitrates round-robin, latches the winning request, sequences one bus access with optional wait states, and returns ack plus registered read data.
- Sits between the masters and all bus slaves (RAM at device 3'b001, peripherals at other selects).

---
 rtl/mem_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : round-robin arbiter sharing one memory/peripheral bus
//                   between a CPU master (m0) and a DMA/UART master (m1).
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned DEV_LSB     = 13,
  parameter logic [2:0]  IDLE_DEV    = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  rd_data,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [2:0]  bus_dev_sel,
  output logic [15:0] bus_addr,
  output logic        bus_we,
  output logic        bus_oe,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam logic [3:0] C_WAIT = WAIT_STATES[3:0];

  logic [1:0]  r_state;
  logic [1:0]  r_grant;
  logic        r_last_m1;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rd_data;

  logic        w_any_req;
  logic        w_pick_m1;
  logic        w_in_access;
  logic        w_in_ack;

  assign w_any_req = m0_req | m1_req;
  // On a tie the master that did not win last time takes the bus.
  assign w_pick_m1 = m1_req & (~m0_req | ~r_last_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= 2'b00;
      r_last_m1 <= 1'b1;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= 16'd0;
      r_wdata   <= 8'd0;
      r_rd_data <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_ACCESS;
            r_grant   <= w_pick_m1 ? 2'b10 : 2'b01;
            r_last_m1 <= w_pick_m1;
            r_cnt     <= C_WAIT;
            r_we      <= w_pick_m1 ? m1_we    : m0_we;
            r_addr    <= w_pick_m1 ? m1_addr  : m0_addr;
            r_wdata   <= w_pick_m1 ? m1_wdata : m0_wdata;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              r_rd_data <= bus_rdata;
            end
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign w_in_access = (r_state == S_ACCESS);
  assign w_in_ack    = (r_state == S_ACK);

  // Bus strobes decode straight from state so reset removes them without a clock.
  assign bus_dev_sel = w_in_access ? r_addr[DEV_LSB+2:DEV_LSB] : IDLE_DEV;
  assign bus_addr    = w_in_access ? r_addr  : 16'd0;
  assign bus_wdata   = w_in_access ? r_wdata : 8'd0;
  assign bus_we      = w_in_access &  r_we;
  assign bus_oe      = w_in_access & ~r_we;

  assign m0_ack  = w_in_ack & r_grant[0];
  assign m1_ack  = w_in_ack & r_grant[1];
  assign grant   = r_grant;
  assign busy    = w_in_access | w_in_ack;
  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : directed and randomized bench for mem_bus_arbiter,
//                      instance d0 has WAIT_STATES=0, instance d1 has 2.
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_a   [2][2];
  logic        we_a    [2][2];
  logic [15:0] addr_a  [2][2];
  logic [7:0]  wd_a    [2][2];
  logic        ack_a   [2][2];
  logic [7:0]  rdata_a [2];
  logic [7:0]  rd_a    [2];
  logic [1:0]  grant_a [2];
  logic        busy_a  [2];
  logic [2:0]  dev_a   [2];
  logic [15:0] baddr_a [2];
  logic        bwe_a   [2];
  logic        boe_a   [2];
  logic [7:0]  bwd_a   [2];

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req_a[0][0]), .m0_we(we_a[0][0]), .m0_addr(addr_a[0][0]),
    .m0_wdata(wd_a[0][0]), .m0_ack(ack_a[0][0]),
    .m1_req(req_a[0][1]), .m1_we(we_a[0][1]), .m1_addr(addr_a[0][1]),
    .m1_wdata(wd_a[0][1]), .m1_ack(ack_a[0][1]),
    .rd_data(rd_a[0]), .grant(grant_a[0]), .busy(busy_a[0]),
    .bus_dev_sel(dev_a[0]), .bus_addr(baddr_a[0]), .bus_we(bwe_a[0]),
    .bus_oe(boe_a[0]), .bus_wdata(bwd_a[0]), .bus_rdata(rdata_a[0])
  );

  mem_bus_arbiter #(.WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req_a[1][0]), .m0_we(we_a[1][0]), .m0_addr(addr_a[1][0]),
    .m0_wdata(wd_a[1][0]), .m0_ack(ack_a[1][0]),
    .m1_req(req_a[1][1]), .m1_we(we_a[1][1]), .m1_addr(addr_a[1][1]),
    .m1_wdata(wd_a[1][1]), .m1_ack(ack_a[1][1]),
    .rd_data(rd_a[1]), .grant(grant_a[1]), .busy(busy_a[1]),
    .bus_dev_sel(dev_a[1]), .bus_addr(baddr_a[1]), .bus_we(bwe_a[1]),
    .bus_oe(boe_a[1]), .bus_wdata(bwd_a[1]), .bus_rdata(rdata_a[1])
  );

  // Reference model: a transaction timeline. Phase 0 = idle, phases
  // 1..WS+1 = bus access, phase WS+2 = acknowledge.
  int          m_phase [2];
  int          m_own   [2];
  int          m_last  [2];
  logic        m_we    [2];
  logic [15:0] m_addr  [2];
  logic [7:0]  m_wd    [2];
  logic [7:0]  m_rd    [2];
  int          m_win;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit in_acc(input int d);
    return (m_phase[d] >= 1) && (m_phase[d] <= ws_of(d) + 1);
  endfunction

  function automatic bit exp_ack(input int d, input int m);
    return (m_phase[d] == ws_of(d) + 2) && (m_own[d] == m);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_phase[d] = 0;
        m_own[d]   = 0;
        m_last[d]  = 1;
        m_we[d]    = 1'b0;
        m_addr[d]  = 16'd0;
        m_wd[d]    = 8'd0;
        m_rd[d]    = 8'd0;
      end else if (m_phase[d] == 0) begin
        if (req_a[d][0] || req_a[d][1]) begin
          if (req_a[d][0] && req_a[d][1]) m_win = 1 - m_last[d];
          else                            m_win = req_a[d][1] ? 1 : 0;
          m_own[d]   = m_win;
          m_last[d]  = m_win;
          m_we[d]    = we_a[d][m_win];
          m_addr[d]  = addr_a[d][m_win];
          m_wd[d]    = wd_a[d][m_win];
          m_phase[d] = 1;
        end
      end else if (m_phase[d] == ws_of(d) + 1) begin
        if (!m_we[d]) m_rd[d] = rdata_a[d];
        m_phase[d] = m_phase[d] + 1;
      end else if (m_phase[d] == ws_of(d) + 2) begin
        m_phase[d] = 0;
      end else begin
        m_phase[d] = m_phase[d] + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      bit a;
      bit k;
      a = in_acc(d);
      k = (m_phase[d] == ws_of(d) + 2);
      check_val($sformatf("d%0d_grant", d), 32'(grant_a[d]),
                (a || k) ? ((m_own[d] == 1) ? 32'd2 : 32'd1) : 32'd0);
      check_val($sformatf("d%0d_busy", d), 32'(busy_a[d]), 32'(a || k));
      check_val($sformatf("d%0d_ack0", d), 32'(ack_a[d][0]), 32'(exp_ack(d, 0)));
      check_val($sformatf("d%0d_ack1", d), 32'(ack_a[d][1]), 32'(exp_ack(d, 1)));
      check_val($sformatf("d%0d_dev", d), 32'(dev_a[d]), a ? 32'(m_addr[d] >> 13) & 32'h7 : 32'd0);
      check_val($sformatf("d%0d_addr", d), 32'(baddr_a[d]), a ? 32'(m_addr[d]) : 32'd0);
      check_val($sformatf("d%0d_we", d), 32'(bwe_a[d]), 32'(a && m_we[d]));
      check_val($sformatf("d%0d_oe", d), 32'(boe_a[d]), 32'(a && !m_we[d]));
      check_val($sformatf("d%0d_wdata", d), 32'(bwd_a[d]), a ? 32'(m_wd[d]) : 32'd0);
      check_val($sformatf("d%0d_rd", d), 32'(rd_a[d]), 32'(m_rd[d]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  task automatic new_fields(input int d, input int m);
    we_a[d][m]   = 1'($urandom_range(1, 0));
    addr_a[d][m] = 16'($urandom);
    wd_a[d][m]   = 8'($urandom);
  endtask

  // Masters drop req in their ack cycle; nobody raises a new request.
  task automatic drain(input int n);
    repeat (n) begin
      step();
      for (int d = 0; d < 2; d++)
        for (int m = 0; m < 2; m++)
          if (req_a[d][m] && exp_ack(d, m)) req_a[d][m] = 1'b0;
    end
  endtask

  task automatic drive_random();
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        if (req_a[d][m]) begin
          if (exp_ack(d, m)) begin
            if ($urandom_range(1, 0) == 0) req_a[d][m] = 1'b0;
            else                           new_fields(d, m);
          end else if (in_acc(d) && m_own[d] == m) begin
            new_fields(d, m);
          end
        end else if ($urandom_range(9, 0) < 4) begin
          req_a[d][m] = 1'b1;
          new_fields(d, m);
        end
      end
      rdata_a[d] = 8'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rdata_a[d] = 8'd0;
      for (int m = 0; m < 2; m++) begin
        req_a[d][m]  = 1'b1;
        we_a[d][m]   = 1'b0;
        addr_a[d][m] = 16'h2000;
        wd_a[d][m]   = 8'd0;
      end
    end

    // Reset held with both masters requesting
    repeat (3) step();
    check_val("rst_grant", 32'(grant_a[0]), 32'd0);
    check_val("rst_dev", 32'(dev_a[0]), 32'd0);
    rst_n = 1'b1;
    step();
    check_val("first_grant_m0", 32'(grant_a[0]), 32'd1);
    drain(16);

    // m0 read, no wait states
    addr_a[0][0] = 16'h20FE; we_a[0][0] = 1'b0; req_a[0][0] = 1'b1;
    rdata_a[0] = 8'h80;
    step();
    check_val("rd_dev", 32'(dev_a[0]), 32'd1);
    check_val("rd_addr", 32'(baddr_a[0]), 32'h20FE);
    check_val("rd_oe", 32'(boe_a[0]), 32'd1);
    step();
    check_val("rd_ack", 32'(ack_a[0][0]), 32'd1);
    check_val("rd_data", 32'(rd_a[0]), 32'h80);
    req_a[0][0] = 1'b0;
    step();

    // m1 write, rd_data must hold
    addr_a[0][1] = 16'h20FF; wd_a[0][1] = 8'h02; we_a[0][1] = 1'b1; req_a[0][1] = 1'b1;
    step();
    check_val("wr_we", 32'(bwe_a[0]), 32'd1);
    check_val("wr_wdata", 32'(bwd_a[0]), 32'h02);
    check_val("wr_oe", 32'(boe_a[0]), 32'd0);
    step();
    check_val("wr_ack", 32'(ack_a[0][1]), 32'd1);
    check_val("wr_rd_hold", 32'(rd_a[0]), 32'h80);
    req_a[0][1] = 1'b0;
    step();

    // Contention: both masters hold req for 12 cycles
    we_a[0][0] = 1'b0; we_a[0][1] = 1'b0;
    req_a[0][0] = 1'b1; req_a[0][1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      check_val($sformatf("cont_ack0_c%0d", c), 32'(ack_a[0][0]), 32'(c == 2 || c == 8));
      check_val($sformatf("cont_ack1_c%0d", c), 32'(ack_a[0][1]), 32'(c == 5 || c == 11));
    end
    req_a[0][0] = 1'b0; req_a[0][1] = 1'b0;
    step();

    // Two wait states: slave data changes every cycle, last access edge wins
    addr_a[1][0] = 16'h4ABC; we_a[1][0] = 1'b0; req_a[1][0] = 1'b1;
    rdata_a[1] = 8'h11;
    step(); rdata_a[1] = 8'h22;
    step(); rdata_a[1] = 8'h33;
    step();
    check_val("ws2_addr_c3", 32'(baddr_a[1]), 32'h4ABC);
    check_val("ws2_dev_c3", 32'(dev_a[1]), 32'd2);
    rdata_a[1] = 8'h44;
    step();
    check_val("ws2_ack", 32'(ack_a[1][0]), 32'd1);
    check_val("ws2_rd", 32'(rd_a[1]), 32'h44);
    req_a[1][0] = 1'b0;
    step();

    // Randomized traffic on both instances
    repeat (3000) begin
      step();
      drive_random();
    end
    drain(30);

    // Reset during a write access
    addr_a[1][1] = 16'h2010; wd_a[1][1] = 8'h5A; we_a[1][1] = 1'b1; req_a[1][1] = 1'b1;
    step();
    check_val("rstmid_we_before", 32'(bwe_a[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rstmid_we_after", 32'(bwe_a[1]), 32'd0);
    check_val("rstmid_ack", 32'(ack_a[1][1]), 32'd0);
    check_val("rstmid_busy", 32'(busy_a[1]), 32'd0);
    req_a[1][1] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    addr_a[1][0] = 16'h2222; we_a[1][0] = 1'b0; req_a[1][0] = 1'b1;
    rdata_a[1] = 8'h77;
    for (int c = 1; c <= 4; c++) step();
    check_val("post_rst_ack", 32'(ack_a[1][0]), 32'd1);
    check_val("post_rst_rd", 32'(rd_a[1]), 32'h77);
    req_a[1][0] = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
